// File: rtl/beam_thresh_loader.sv
// beam_thresh_loader
//
// Holds two sets of 18-bit trigger thresholds per beam and, on a commit,
// streams them pair-by-pair into the beamformer's cascaded threshold chain,
// then pulses the update strobe for the sets that were loaded.
//
// Ports:
//   clk_i, rst_i        sole clock; synchronous active-high reset
//   cfg_wr_i            threshold write strobe
//   cfg_beam_i          beam index of the write
//   cfg_sel_i           threshold set (0/1) of the write
//   cfg_data_i          18-bit threshold value
//   cfg_ready_o         high while writes are accepted (not busy)
//   cfg_drop_o          sticky: a write was dropped (busy or bad beam)
//   commit_i            start-load request
//   commit_mask_i       sets to load, bit k selects set k
//   busy_o              a load sequence is in progress
//   done_o              one-cycle pulse when a sequence completes
//   thresh_o            {beam 2p+1, beam 2p} threshold word for the cascade
//   thresh_wr_o         cascade shift strobe, one bit per set
//   thresh_update_o     update strobe, one bit per set
module beam_thresh_loader #(
  parameter int          NBEAMS      = 2,
  parameter logic [17:0] THRESH_INIT = 18'h3FFFF,
  parameter int          SETTLE      = 2,
  parameter string       AUTOLOAD    = "TRUE"
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         cfg_wr_i,
  input  logic [((NBEAMS > 1) ? $clog2(NBEAMS) : 1)-1:0] cfg_beam_i,
  input  logic                                         cfg_sel_i,
  input  logic [17:0]                                  cfg_data_i,
  output logic                                         cfg_ready_o,
  output logic                                         cfg_drop_o,
  input  logic                                         commit_i,
  input  logic [1:0]                                   commit_mask_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic [35:0]                                  thresh_o,
  output logic [1:0]                                   thresh_wr_o,
  output logic [1:0]                                   thresh_update_o
);

  localparam int             BW      = (NBEAMS > 1) ? $clog2(NBEAMS) : 1;
  localparam int             NPAIR   = (NBEAMS + 1) / 2;
  localparam int             PW      = (NPAIR > 1) ? $clog2(NPAIR) : 1;
  localparam logic [PW-1:0]  PLAST   = PW'(NPAIR - 1);
  localparam bit             AUTO_EN = (AUTOLOAD == "TRUE");

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_UPDATE
  } state_t;

  state_t         state;
  logic [1:0]     mask_q;
  logic           set_k;
  logic [PW-1:0]  pair_p;
  logic [3:0]     settle_cnt;
  logic           auto_pend;

  logic [17:0]    thr0 [NBEAMS];
  logic [17:0]    thr1 [NBEAMS];
  logic [17:0]    rd0  [NBEAMS];
  logic [17:0]    rd1  [NBEAMS];

  logic           beam_ok;
  logic           wr_acc;
  logic           start_go;
  logic [1:0]     start_mask;
  logic           nxt_valid;
  logic           nxt_k;
  logic [PW-1:0]  nxt_p;
  logic [17:0]    word_lo;
  logic [17:0]    word_hi;

  // When NBEAMS fills the index width every index is a real beam, so the
  // range check collapses to a constant instead of a always-true compare.
  if (NBEAMS == (1 << BW)) begin : g_beam_full
    assign beam_ok = 1'b1;
  end else begin : g_beam_part
    assign beam_ok = (int'(cfg_beam_i) < NBEAMS);
  end

  assign cfg_ready_o = ~busy_o;
  assign wr_acc      = cfg_wr_i & ~busy_o & beam_ok;

  // Threshold register file plus the sticky drop flag. Writes are only
  // taken while idle; anything arriving while busy or aimed at a missing
  // beam is discarded and remembered in cfg_drop_o until reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NBEAMS; b++) begin
        thr0[b] <= THRESH_INIT;
        thr1[b] <= THRESH_INIT;
      end
      cfg_drop_o <= 1'b0;
    end else begin
      if (wr_acc) begin
        if (cfg_sel_i) begin
          thr1[cfg_beam_i] <= cfg_data_i;
        end else begin
          thr0[cfg_beam_i] <= cfg_data_i;
        end
      end
      if (cfg_wr_i && (busy_o || !beam_ok)) begin
        cfg_drop_o <= 1'b1;
      end
    end
  end

  // Forwarded view of the register file: a write landing on the same edge
  // that starts a load must already appear in the first word shifted out,
  // because the first cascade word is registered on that very edge.
  always_comb begin
    for (int b = 0; b < NBEAMS; b++) begin
      rd0[b] = thr0[b];
      rd1[b] = thr1[b];
      if (wr_acc && (int'(cfg_beam_i) == b)) begin
        if (cfg_sel_i) begin
          rd1[b] = cfg_data_i;
        end else begin
          rd0[b] = cfg_data_i;
        end
      end
    end
  end

  // Decide which (set, pair) word goes onto the cascade in the next cycle.
  // Pairs are walked from the farthest one down to pair 0 so that after
  // NPAIR shifts each stage of the chain holds its own value; set 0 runs
  // before set 1 with no bubble between them.
  always_comb begin
    start_mask = auto_pend ? 2'b11 : commit_mask_i;
    start_go   = (state == S_IDLE) &&
                 (auto_pend || (commit_i && (commit_mask_i != 2'b00)));
    nxt_valid  = 1'b0;
    nxt_k      = 1'b0;
    nxt_p      = PLAST;
    case (state)
      S_IDLE: begin
        nxt_valid = start_go;
        nxt_k     = ~start_mask[0];
      end
      S_LOAD: begin
        if (pair_p != '0) begin
          nxt_valid = 1'b1;
          nxt_k     = set_k;
          nxt_p     = pair_p - PW'(1);
        end else if (!set_k && mask_q[1]) begin
          nxt_valid = 1'b1;
          nxt_k     = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Gather the two beams of the selected pair. The upper half of the last
  // pair stays zero when the beam count is odd.
  always_comb begin
    word_lo = '0;
    word_hi = '0;
    for (int b = 0; b < NBEAMS; b++) begin
      if (b == 2 * int'(nxt_p)) begin
        word_lo = nxt_k ? rd1[b] : rd0[b];
      end
      if (b == 2 * int'(nxt_p) + 1) begin
        word_hi = nxt_k ? rd1[b] : rd0[b];
      end
    end
  end

  // Load sequencer. Every output is registered here; strobes and the data
  // word default to zero each cycle so thresh_o is only non-zero alongside
  // a shift strobe. The autoload request is a one-shot armed by reset and
  // takes priority over any external commit in the same cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= S_IDLE;
      mask_q          <= 2'b00;
      set_k           <= 1'b0;
      pair_p          <= '0;
      settle_cnt      <= 4'd0;
      auto_pend       <= AUTO_EN;
      thresh_o        <= '0;
      thresh_wr_o     <= 2'b00;
      thresh_update_o <= 2'b00;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
    end else begin
      auto_pend       <= 1'b0;
      done_o          <= 1'b0;
      thresh_update_o <= 2'b00;
      thresh_o        <= '0;
      thresh_wr_o     <= 2'b00;
      if (nxt_valid) begin
        thresh_o    <= {word_hi, word_lo};
        thresh_wr_o <= nxt_k ? 2'b10 : 2'b01;
        set_k       <= nxt_k;
        pair_p      <= nxt_p;
      end
      case (state)
        S_IDLE: begin
          if (start_go) begin
            state  <= S_LOAD;
            mask_q <= start_mask;
            busy_o <= 1'b1;
          end
        end
        S_LOAD: begin
          if (!nxt_valid) begin
            if (SETTLE == 0) begin
              state           <= S_UPDATE;
              thresh_update_o <= mask_q;
            end else begin
              state      <= S_SETTLE;
              settle_cnt <= 4'(SETTLE - 1);
            end
          end
        end
        S_SETTLE: begin
          if (settle_cnt == 4'd0) begin
            state           <= S_UPDATE;
            thresh_update_o <= mask_q;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        S_UPDATE: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b1;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beam_thresh_loader.sv
// tb_beam_thresh_loader
//
// Bench for beam_thresh_loader with five beams (odd pair count), a two
// cycle settle gap and autoload enabled. A directed table covers reset and
// the autoload sequence, hand sequences cover ordering, odd beams, drops,
// same-cycle write/commit and mid-sequence reset, and a random phase is
// checked every cycle against a queue-based reference model.
module tb_beam_thresh_loader;

  localparam int          NB   = 5;
  localparam int          ST   = 2;
  localparam int          NP   = (NB + 1) / 2;
  localparam logic [17:0] INIT = 18'h3FFFF;
  localparam logic [35:0] HW   = {18'h0, INIT};
  localparam logic [35:0] FW   = {INIT, INIT};

  typedef struct packed {
    logic [35:0] th;
    logic [1:0]  wr;
    logic [1:0]  upd;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        wr;
    logic [2:0]  beam;
    logic        sel;
    logic [17:0] data;
    logic        commit;
    logic [1:0]  mask;
    exp_t        e;
    logic        drop;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_wr;
  logic [2:0]  cfg_beam;
  logic        cfg_sel;
  logic [17:0] cfg_data;
  logic        cfg_ready;
  logic        cfg_drop;
  logic        commit;
  logic [1:0]  commit_mask;
  logic        busy;
  logic        done;
  logic [35:0] thresh;
  logic [1:0]  thresh_wr;
  logic [1:0]  thresh_upd;

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  logic [17:0] m_thr [NB][2];
  exp_t        m_q[$];
  exp_t        cur;
  exp_t        m_e;
  logic        m_drop;
  logic        m_auto;
  logic        m_go;
  logic [1:0]  m_mask;

  logic [35:0] log_th[$];
  logic [1:0]  log_wr[$];
  int          upd_cnt = 0;
  logic [1:0]  last_upd = 2'b00;

  vec_t tbl[$];

  // 100 MHz free-running clock.
  always #5 clk = ~clk;

  beam_thresh_loader #(
    .NBEAMS(NB),
    .THRESH_INIT(INIT),
    .SETTLE(ST),
    .AUTOLOAD("TRUE")
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .cfg_wr_i(cfg_wr),
    .cfg_beam_i(cfg_beam),
    .cfg_sel_i(cfg_sel),
    .cfg_data_i(cfg_data),
    .cfg_ready_o(cfg_ready),
    .cfg_drop_o(cfg_drop),
    .commit_i(commit),
    .commit_mask_i(commit_mask),
    .busy_o(busy),
    .done_o(done),
    .thresh_o(thresh),
    .thresh_wr_o(thresh_wr),
    .thresh_update_o(thresh_upd)
  );

  // Reference model: on every edge apply the write rules to a plain array,
  // and when a load starts push the whole expected output trace (one record
  // per cycle) onto a queue; each cycle pops the next record or idles.
  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      for (int b = 0; b < NB; b++) begin
        m_thr[b][0] = INIT;
        m_thr[b][1] = INIT;
      end
      m_drop = 1'b0;
      m_auto = 1'b1;
      cur    = '0;
    end else begin
      if (cfg_wr && (cur.busy || int'(cfg_beam) >= NB)) begin
        m_drop = 1'b1;
      end else if (cfg_wr) begin
        m_thr[cfg_beam][cfg_sel] = cfg_data;
      end
      m_go   = !cur.busy && (m_auto || (commit && commit_mask != 2'b00));
      m_mask = m_auto ? 2'b11 : commit_mask;
      m_auto = 1'b0;
      if (m_go) begin
        for (int k = 0; k < 2; k++) begin
          if (m_mask[k]) begin
            for (int p = NP - 1; p >= 0; p--) begin
              m_e          = '0;
              m_e.wr       = (k == 0) ? 2'b01 : 2'b10;
              m_e.th[17:0] = m_thr[2 * p][k];
              if (2 * p + 1 < NB) begin
                m_e.th[35:18] = m_thr[2 * p + 1][k];
              end
              m_e.busy = 1'b1;
              m_q.push_back(m_e);
            end
          end
        end
        for (int s = 0; s < ST; s++) begin
          m_e      = '0;
          m_e.busy = 1'b1;
          m_q.push_back(m_e);
        end
        m_e      = '0;
        m_e.upd  = m_mask;
        m_e.busy = 1'b1;
        m_q.push_back(m_e);
        m_e      = '0;
        m_e.done = 1'b1;
        m_q.push_back(m_e);
      end
      cur = (m_q.size() > 0) ? m_q.pop_front() : '0;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge,
  // plus a log of shifted words and update pulses for the directed checks.
  always @(negedge clk) begin
    if (check_en) begin
      n_vec++;
      if ({thresh, thresh_wr, thresh_upd, busy, done, cfg_drop, cfg_ready} !==
          {cur, m_drop, ~cur.busy}) begin
        n_err++;
        $display("[TB] FAIL model_cycle t=%0t: actual th=%h wr=%b upd=%b busy=%b done=%b drop=%b rdy=%b, required th=%h wr=%b upd=%b busy=%b done=%b drop=%b rdy=%b",
                 $time, thresh, thresh_wr, thresh_upd, busy, done, cfg_drop, cfg_ready,
                 cur.th, cur.wr, cur.upd, cur.busy, cur.done, m_drop, ~cur.busy);
      end
      if (thresh_wr != 2'b00) begin
        log_th.push_back(thresh);
        log_wr.push_back(thresh_wr);
      end
      if (thresh_upd != 2'b00) begin
        upd_cnt++;
        last_upd = thresh_upd;
      end
    end
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mk(logic r, logic w, logic [2:0] b, logic s,
                              logic [17:0] d, logic c, logic [1:0] m,
                              logic [35:0] th = '0, logic [1:0] ew = 2'b00,
                              logic [1:0] eu = 2'b00, logic eb = 1'b0,
                              logic ed = 1'b0, logic edr = 1'b0);
    vec_t v;
    v.rst    = r;
    v.wr     = w;
    v.beam   = b;
    v.sel    = s;
    v.data   = d;
    v.commit = c;
    v.mask   = m;
    v.e.th   = th;
    v.e.wr   = ew;
    v.e.upd  = eu;
    v.e.busy = eb;
    v.e.done = ed;
    v.drop   = edr;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst         = v.rst;
    cfg_wr      = v.wr;
    cfg_beam    = v.beam;
    cfg_sel     = v.sel;
    cfg_data    = v.data;
    commit      = v.commit;
    commit_mask = v.mask;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s: actual %h, required %h", name, act, req);
    end
  endtask

  task automatic idle();
    applyStimulus(mk(1'b0, 1'b0, 3'd0, 1'b0, 18'd0, 1'b0, 2'b00));
  endtask

  task automatic cfgWrite(input logic [2:0] b, input logic s, input logic [17:0] d);
    applyStimulus(mk(1'b0, 1'b1, b, s, d, 1'b0, 2'b00));
    @(negedge clk);
    idle();
  endtask

  task automatic doCommit(input logic [1:0] m);
    applyStimulus(mk(1'b0, 1'b0, 3'd0, 1'b0, 18'd0, 1'b1, m));
    @(negedge clk);
    idle();
  endtask

  task automatic doReset();
    applyStimulus(mk(1'b1, 1'b0, 3'd0, 1'b0, 18'd0, 1'b0, 2'b00));
    @(negedge clk);
    @(negedge clk);
    idle();
  endtask

  task automatic waitDone(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput(name, 64'(seen), 64'd1);
  endtask

  task automatic clearLog();
    log_th.delete();
    log_wr.delete();
  endtask

  task automatic checkLog(input string name, input int idx,
                          input logic [35:0] th, input logic [1:0] wr);
    logic [35:0] a_th = '0;
    logic [1:0]  a_wr = '0;
    if (idx < log_th.size()) begin
      a_th = log_th[idx];
      a_wr = log_wr[idx];
    end
    checkOutput(name, {26'd0, a_wr, a_th}, {26'd0, wr, th});
  endtask

  initial begin
    vec_t v;
    int   upd0;

    applyStimulus(mk(1'b1, 1'b0, 3'd0, 1'b0, 18'd0, 1'b0, 2'b00));
    @(negedge clk);
    check_en = 1'b1;

    // Reset, then the autoload of all-INIT thresholds, with one write
    // arriving mid-load (dropped) and a mask-0 commit in the done cycle.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, HW, 2'b01, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, FW, 2'b01, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 0, 18'h123, 0, 2'b00, FW, 2'b01, 2'b00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, HW, 2'b10, 2'b00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, FW, 2'b10, 2'b00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, FW, 2'b10, 2'b00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b00, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b11, 1, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b00, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 2'b00, '0, 2'b00, 2'b00, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 2'b00, '0, 2'b00, 2'b00, 0, 0, 1));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      @(negedge clk);
      checkOutput($sformatf("table[%0d]", i),
                  64'({thresh, thresh_wr, thresh_upd, busy, done, cfg_drop, cfg_ready}),
                  64'({tbl[i].e, tbl[i].drop, ~tbl[i].e.busy}));
    end
    idle();

    // Ordering: set 0 loaded farthest pair first.
    for (int b = 0; b < NB; b++) begin
      cfgWrite(3'(b), 1'b0, 18'(b + 1));
    end
    clearLog();
    doCommit(2'b01);
    waitDone("order_done", 40);
    checkOutput("order_len", 64'(log_th.size()), 64'd3);
    checkLog("order_w0", 0, {18'd0, 18'd5}, 2'b01);
    checkLog("order_w1", 1, {18'd4, 18'd3}, 2'b01);
    checkLog("order_w2", 2, {18'd2, 18'd1}, 2'b01);
    checkOutput("order_upd", 64'(last_upd), 64'(2'b01));

    // Odd beam count on set 1: the last pair carries a zero upper half.
    for (int b = 0; b < NB; b++) begin
      cfgWrite(3'(b), 1'b1, 18'(b + 10));
    end
    clearLog();
    doCommit(2'b10);
    waitDone("odd_done", 40);
    checkOutput("odd_len", 64'(log_th.size()), 64'd3);
    checkLog("odd_w0", 0, {18'd0, 18'd14}, 2'b10);
    checkLog("odd_w1", 1, {18'd13, 18'd12}, 2'b10);
    checkLog("odd_w2", 2, {18'd11, 18'd10}, 2'b10);
    checkOutput("odd_upd", 64'(last_upd), 64'(2'b10));

    // Write and commit in the same idle cycle: the write is loaded.
    clearLog();
    applyStimulus(mk(1'b0, 1'b1, 3'd1, 1'b0, 18'd7, 1'b1, 2'b01));
    @(negedge clk);
    idle();
    waitDone("same_done", 40);
    checkLog("same_w2", 2, {18'd7, 18'd1}, 2'b01);

    // Drops: out-of-range beam in idle raises the flag; a write while busy
    // keeps it high and leaves storage untouched.
    doReset();
    waitDone("drop_auto_done", 40);
    checkOutput("drop_clear", 64'(cfg_drop), 64'd0);
    cfgWrite(3'd5, 1'b0, 18'd55);
    checkOutput("drop_oob", 64'(cfg_drop), 64'd1);
    doCommit(2'b01);
    cfgWrite(3'd2, 1'b0, 18'd99);
    waitDone("drop_busy_done", 40);
    checkOutput("drop_sticky", 64'(cfg_drop), 64'd1);
    clearLog();
    doCommit(2'b01);
    waitDone("drop_reload_done", 40);
    checkLog("drop_w0", 0, HW, 2'b01);
    checkLog("drop_w1", 1, FW, 2'b01);
    checkLog("drop_w2", 2, FW, 2'b01);

    // Reset on the second load cycle: no update, then a fresh autoload.
    cfgWrite(3'd0, 1'b1, 18'd42);
    doCommit(2'b11);
    @(negedge clk);
    applyStimulus(mk(1'b1, 1'b0, 3'd0, 1'b0, 18'd0, 1'b0, 2'b00));
    upd0 = upd_cnt;
    @(negedge clk);
    checkOutput("midrst_wr", 64'(thresh_wr), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    clearLog();
    idle();
    waitDone("midrst_auto_done", 40);
    checkOutput("midrst_upd_cnt", 64'(upd_cnt - upd0), 64'd1);
    checkOutput("midrst_upd", 64'(last_upd), 64'(2'b11));
    checkOutput("midrst_len", 64'(log_th.size()), 64'd6);
    checkLog("midrst_w5", 5, FW, 2'b10);

    // Random traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 600; i++) begin
      v = mk(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) == 0),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             18'($urandom), ($urandom_range(0, 5) == 0),
             2'($urandom_range(0, 3)));
      applyStimulus(v);
      @(negedge clk);
    end
    idle();
    repeat (20) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/beam_thresh_loader.md
# beam_thresh_loader

Loads per-beam trigger thresholds into the cascaded threshold chain of the dual-beam L1 beamformer array, and sequences the update. It holds an 18-bit threshold for each beam and each of the two threshold sets in a local register file written by the config side. On a commit, it streams the values pair-by-pair onto the beamformer's `thresh_i`/`thresh_wr_i` cascade, then pulses `thresh_update_i`. It sits between the SURF register bank and the beamform trigger block, and drives that block's threshold ports directly.

## Interface
- `NBEAMS`, default 2: beams in the attached beamformer, 1..64. NPAIR = (NBEAMS+1)/2.
- `THRESH_INIT`, default 18'h3FFFF: reset value of every stored threshold.
- `SETTLE`, default 2: idle cycles between the last cascade write and the update pulse, 0..15.
- `AUTOLOAD`, default "TRUE": perform a mask-2'b11 commit automatically after reset.
- `clk_i`, in, 1: sole clock.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `cfg_wr_i`, in, 1: threshold write strobe.
- `cfg_beam_i`, in, $clog2(NBEAMS) (min 1): beam index.
- `cfg_sel_i`, in, 1: threshold set, 0 or 1.
- `cfg_data_i`, in, 18: threshold value.
- `cfg_ready_o`, out, 1: write port accepting writes (= !busy_o).
- `cfg_drop_o`, out, 1: sticky flag, set when a write is dropped.
- `commit_i`, in, 1: start-load request.
- `commit_mask_i`, in, 2: threshold sets to load; bit k selects set k.
- `busy_o`, out, 1: a load sequence is in progress.
- `done_o`, out, 1: one-cycle pulse when a sequence completes.
- `thresh_o`, out, 36: {beam B threshold, beam A threshold}; connects to `thresh_i`.
- `thresh_wr_o`, out, 2: connects to `thresh_wr_i`.
- `thresh_update_o`, out, 2: connects to `thresh_update_i`.

## Operation
- **Storage:** thr[b][s], NBEAMS×2×18 bits, all initialised to THRESH_INIT by reset.
- **Config writes:**
  - A write with cfg_wr_i=1 and cfg_ready_o=1 updates thr[cfg_beam_i][cfg_sel_i] at that edge.
  - cfg_beam_i ≥ NBEAMS: the write is dropped and cfg_drop_o is set.
  - cfg_wr_i=1 while busy_o=1: the write is dropped and cfg_drop_o is set.
  - cfg_drop_o clears only on reset.
- **FSM states:** IDLE, LOAD, SETTLE, UPDATE.
  - IDLE → LOAD when commit_i=1 and commit_mask_i≠0. The mask is latched.
  - commit_i with mask 0 is ignored.
  - commit_i in any state other than IDLE is ignored.
  - LOAD: for each selected set k, set 0 before set 1, and for p = NPAIR-1 down to 0, one cycle with:
    - thresh_wr_o = (1<<k)
    - thresh_o = {thr[2p+1][k], thr[2p][k]}
    - When 2p+1 = NBEAMS (odd NBEAMS), the upper half is 18'h0.
    - The farthest pair is written first, so after NPAIR shifts each pair holds its own value.
  - SETTLE: SETTLE cycles with all outputs idle; skipped when SETTLE=0.
  - UPDATE: one cycle with thresh_update_o = latched mask, then return to IDLE with a done_o pulse.
- **Write and commit in the same IDLE cycle:** the write lands first and is included in the load.
- **AUTOLOAD:** the first cycle with rst_i=0 after reset behaves as commit_i=1 with mask 2'b11. An external commit in that same cycle is ignored.
- **Reset mid-sequence:** the sequence aborts the same edge. No update pulse is issued. Storage returns to THRESH_INIT. Then AUTOLOAD applies.

## Timing
- All outputs are registered.
- Reset values:
  - thresh_o = 0, thresh_wr_o = 0, thresh_update_o = 0
  - busy_o = 0, done_o = 0, cfg_drop_o = 0
  - cfg_ready_o = 1 while rst_i is high.
- thresh_o is 0 whenever thresh_wr_o = 0.
- With commit accepted at edge T0 and L = popcount(mask)·NPAIR:
  - thresh_wr_o is high in cycles T0+1 .. T0+L, with no gaps, including across the set-0 → set-1 change.
  - thresh_update_o is high in cycle T0+L+SETTLE+1.
  - done_o and cfg_ready_o=1 are in cycle T0+L+SETTLE+2.
  - busy_o is high in cycles T0+1 .. T0+L+SETTLE+1.
- A new commit is accepted in the done_o cycle, giving back-to-back sequences with one non-busy cycle between them.
- Write-to-storage latency is 1 cycle; a write is visible to a LOAD that starts at the next edge.

## Test plan
- **Reset/autoload** (NBEAMS=4, SETTLE=2):
  - Stimulus: release reset.
  - Required: thresh_wr_o=01 for 2 cycles, then 10 for 2 cycles, all with thresh_o=36'hFFFFFFFFF. Then 2 idle cycles, thresh_update_o=11 for 1 cycle, then done_o.
- **Ordering** (NBEAMS=4, AUTOLOAD="FALSE"):
  - Stimulus: write thr[b][0]=b+1, then commit mask 01.
  - Required: thresh_o = {18'd4,18'd3}, then {18'd2,18'd1}; thresh_update_o=01.
- **Odd beams** (NBEAMS=5):
  - Stimulus: set-1 thresholds 10..14, commit mask 10.
  - Required: 3 writes with thresh_wr_o=10. The first write is {0,14}, then {13,12}, then {11,10}.
- **Drops:**
  - Stimulus: cfg_wr_i during busy; then a write with cfg_beam_i=NBEAMS in IDLE.
  - Required: cfg_drop_o rises on the first and stays high. Storage is unchanged; a reload shows the old values.
- **Same-cycle write and commit:**
  - Stimulus: write thr[1][0]=7 together with commit mask 01.
  - Required: 7 appears in the loaded data.
- **Mid-sequence reset:**
  - Stimulus: assert rst_i on the second LOAD cycle.
  - Required: thresh_wr_o=0 the next cycle, no thresh_update_o pulse, then a fresh autoload of THRESH_INIT.
